// File: rtl/pkg_sv_sdr_types.sv
// pkg_sv_sdr_types: shared SDR datapath types (I/Q fixed-point pair, integrate-and-dump state).
`default_nettype none

package pkg_sv_sdr_types;

  localparam int IQ_FIX_W = 16;

  typedef struct packed {
    logic signed [IQ_FIX_W-1:0] i;
    logic signed [IQ_FIX_W-1:0] q;
  } t_iq_fix;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } t_iqd_state;

endpackage

`default_nettype wire

// File: rtl/iq_shift_sat.sv
// iq_shift_sat: arithmetic right shift and saturation of one signed component.
// Define IQ_DUMP_ROUND_EN to add round-half-up ahead of the shift.
`default_nettype none

module iq_shift_sat #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic        [SH_W-1:0]  shift,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

`ifdef IQ_DUMP_ROUND_EN
  // One guard bit so the rounding bias can never wrap the sum.
  localparam int EW = IN_W + 1;
  logic signed [EW-1:0] bias;
  logic signed [EW-1:0] ext;

  always_comb begin
    bias = '0;
    if (shift != '0) bias = EW'(1) << (shift - SH_W'(1));
    ext = {din[IN_W-1], din} + bias;
  end
`else
  localparam int EW = IN_W;
  logic signed [EW-1:0] ext;

  assign ext = din;
`endif

  localparam logic signed [EW-1:0] MAX_V = EW'((longint'(1) << (OUT_W-1)) - 1);
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic signed [EW-1:0] shifted;

  always_comb begin
    shifted = ext >>> shift;
`ifdef IQ_DUMP_ROUND_EN
    // Beyond IN_W the bias alone exceeds any sum, so the rounded result is exactly zero.
    if (32'(shift) > 32'(IN_W)) shifted = '0;
`endif
    sat  = 1'b0;
    dout = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iq_integrate_dump.sv
// iq_integrate_dump: integrate-and-dump I/Q decimator with valid/ready flow control.
// Optional feature macro: IQ_DUMP_ROUND_EN (round half up before scaling; default truncates).
`default_nettype none

module iq_integrate_dump
  import pkg_sv_sdr_types::*;
#(
  parameter int IQ_W  = 16,
  parameter int N_MAX = 64,
  parameter int ACC_W = IQ_W + $clog2(N_MAX)
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic [$clog2(N_MAX+1)-1:0]   iratio,
  input  logic [$clog2(ACC_W)-1:0]     ishift,
  input  logic                         i_valid,
  output logic                         o_ready_in,
  input  logic signed [IQ_W-1:0]       i_i,
  input  logic signed [IQ_W-1:0]       i_q,
  output logic                         o_valid,
  input  logic                         i_ready_out,
  output logic signed [IQ_W-1:0]       o_i,
  output logic signed [IQ_W-1:0]       o_q,
  output logic                         o_sat
);

  localparam int RW = $clog2(N_MAX+1);
  localparam int SW = $clog2(ACC_W);

  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic        [RW-1:0]    cnt;
  logic        [RW-1:0]    ratio_lat;
  logic        [RW-1:0]    ratio_eff;
  logic        [RW-1:0]    ratio_cur;
  t_iqd_state              state;
  logic                    last;
  logic                    stall;
  logic                    in_xfer;
  logic                    load;
  logic signed [IQ_W-1:0]  sc_i;
  logic signed [IQ_W-1:0]  sc_q;
  logic                    sat_i;
  logic                    sat_q;
  logic                    unused_full;

  always_comb begin
    if (iratio == '0)
      ratio_eff = RW'(1);
    else if (32'(iratio) > 32'(N_MAX))
      ratio_eff = RW'(N_MAX);
    else
      ratio_eff = iratio;
  end

  // At the start of a run the ratio that will be latched is the live one.
  assign ratio_cur = (cnt == '0) ? ratio_eff : ratio_lat;
  assign last      = (cnt == ratio_cur - RW'(1));
  assign stall     = last && o_valid && !i_ready_out;
  assign o_ready_in = !stall;
  assign in_xfer   = i_valid && !stall;
  assign load      = in_xfer && last;

  assign sum_i = acc_i + {{(ACC_W-IQ_W){i_i[IQ_W-1]}}, i_i};
  assign sum_q = acc_q + {{(ACC_W-IQ_W){i_q[IQ_W-1]}}, i_q};

  iq_shift_sat #(
    .IN_W  (ACC_W),
    .OUT_W (IQ_W),
    .SH_W  (SW)
  ) u_sat_i (
    .din   (sum_i),
    .shift (ishift),
    .dout  (sc_i),
    .sat   (sat_i)
  );

  iq_shift_sat #(
    .IN_W  (ACC_W),
    .OUT_W (IQ_W),
    .SH_W  (SW)
  ) u_sat_q (
    .din   (sum_q),
    .shift (ishift),
    .dout  (sc_q),
    .sat   (sat_q)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= ACCUM;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      ratio_lat <= RW'(1);
      o_valid   <= 1'b0;
      o_i       <= '0;
      o_q       <= '0;
      o_sat     <= 1'b0;
    end else begin
      state <= (i_valid && stall) ? FULL : ACCUM;

      if (in_xfer) begin
        if (cnt == '0) ratio_lat <= ratio_eff;
        if (last) begin
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + RW'(1);
        end
      end

      // A load in the same cycle as a drain simply replaces the old sample.
      if (load) begin
        o_valid <= 1'b1;
        o_i     <= sc_i;
        o_q     <= sc_q;
        o_sat   <= sat_i | sat_q;
      end else if (i_ready_out) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign unused_full = (state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_iq_integrate_dump.sv
// tb_iq_integrate_dump: directed and randomized checks against a queue-based reference model.
`default_nettype none

module tb_iq_integrate_dump;

  localparam int IQ_W  = 16;
  localparam int N_MAX = 64;
  localparam int ACC_W = IQ_W + $clog2(N_MAX);
  localparam int RW    = $clog2(N_MAX+1);
  localparam int SW    = $clog2(ACC_W);
`ifdef IQ_DUMP_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [RW-1:0]          iratio;
  logic [SW-1:0]          ishift;
  logic                   i_valid;
  logic                   o_ready_in;
  logic signed [IQ_W-1:0] i_i;
  logic signed [IQ_W-1:0] i_q;
  logic                   o_valid;
  logic                   i_ready_out;
  logic signed [IQ_W-1:0] o_i;
  logic signed [IQ_W-1:0] o_q;
  logic                   o_sat;

  always #5 clk = ~clk;

  iq_integrate_dump #(
    .IQ_W  (IQ_W),
    .N_MAX (N_MAX)
  ) dut (
    .iclk        (clk),
    .irst_n      (rst_n),
    .iratio      (iratio),
    .ishift      (ishift),
    .i_valid     (i_valid),
    .o_ready_in  (o_ready_in),
    .i_i         (i_i),
    .i_q         (i_q),
    .o_valid     (o_valid),
    .i_ready_out (i_ready_out),
    .o_i         (o_i),
    .o_q         (o_q),
    .o_sat       (o_sat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: whole-run sums in plain integers, pending outputs in a queue.
  typedef struct {
    longint i;
    longint q;
    bit     sat;
  } t_exp;

  t_exp   exp_q[$];
  longint obs_i[$];
  longint obs_q[$];
  bit     obs_sat[$];
  int     m_cnt;
  int     m_ratio;
  longint m_si;
  longint m_sq;
  bit     last_acc;

  function automatic int eff(input int r);
    if (r == 0) return 1;
    if (r > N_MAX) return N_MAX;
    return r;
  endfunction

  function automatic longint scale(input longint s, input int sh, output bit clip);
    longint v;
    v = s;
    if (ROUND && sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    clip = 1'b0;
    if (v > 32767) begin
      v = 32767;
      clip = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      clip = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt   = 0;
    m_ratio = 1;
    m_si    = 0;
    m_sq    = 0;
  endtask

  task automatic clear_obs();
    obs_i.delete();
    obs_q.delete();
    obs_sat.delete();
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit   exp_valid, exp_ready, acc, drain, ci, cq;
    int   cur, sh;
    t_exp e;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    check_val("o_valid", o_valid, exp_valid);
    if (exp_valid && o_valid) begin
      check_val("o_i", o_i, exp_q[0].i);
      check_val("o_q", o_q, exp_q[0].q);
      check_val("o_sat", o_sat, exp_q[0].sat);
    end
    cur = (m_cnt == 0) ? eff(int'(iratio)) : m_ratio;
    exp_ready = !((m_cnt == cur - 1) && exp_valid && !i_ready_out);
    check_val("o_ready_in", o_ready_in, exp_ready);
    acc   = i_valid && exp_ready;
    drain = exp_valid && i_ready_out;
    sh    = int'(ishift);
    if (drain && o_valid) begin
      obs_i.push_back(o_i);
      obs_q.push_back(o_q);
      obs_sat.push_back(o_sat);
    end
    @(posedge clk);
    if (drain) void'(exp_q.pop_front());
    if (acc) begin
      if (m_cnt == 0) m_ratio = cur;
      m_si += i_i;
      m_sq += i_q;
      m_cnt++;
      if (m_cnt == m_ratio) begin
        e.i   = scale(m_si, sh, ci);
        e.q   = scale(m_sq, sh, cq);
        e.sat = ci | cq;
        exp_q.push_back(e);
        m_cnt = 0;
        m_si  = 0;
        m_sq  = 0;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input int n, input int vi, input int vq);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_i = IQ_W'(vi);
      i_q = IQ_W'(vq);
      cycle();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; iratio = RW'(1); ishift = '0; i_valid = 1'b0;
    i_i = '0; i_q = '0; i_ready_out = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_o_valid", o_valid, 0);
    check_val("rst_o_i", o_i, 0);
    check_val("rst_o_q", o_q, 0);
    check_val("rst_o_sat", o_sat, 0);
    check_val("rst_ready", o_ready_in, 1);
    rst_n = 1'b1;
    model_reset();

    // Ramp, ratio 4
    iratio = RW'(4); clear_obs();
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_i = IQ_W'(k); i_q = IQ_W'(-k);
      cycle();
    end
    i_valid = 1'b0;
    repeat (2) cycle();
    check_val("ramp_cnt", obs_i.size(), 2);
    check_val("ramp_i0", obs_i[0], 10);
    check_val("ramp_q0", obs_q[0], -10);
    check_val("ramp_i1", obs_i[1], 26);
    check_val("ramp_q1", obs_q[1], -26);

    // Saturation, then shifted back in range
    iratio = RW'(64); clear_obs();
    send(64, 32767, -32768);
    repeat (2) cycle();
    ishift = SW'(6);
    send(64, 32767, -32768);
    repeat (2) cycle();
    check_val("sat_cnt", obs_i.size(), 2);
    check_val("sat_i0", obs_i[0], 32767);
    check_val("sat_q0", obs_q[0], -32768);
    check_val("sat_f0", obs_sat[0], 1);
    check_val("sh6_i", obs_i[1], 32767);
    check_val("sh6_q", obs_q[1], -32768);
    check_val("sh6_sat", obs_sat[1], 0);
    ishift = '0;

    // Backpressure with ratio 1
    iratio = RW'(1); clear_obs();
    i_ready_out = 1'b0; i_valid = 1'b1; i_i = 16'sd100; i_q = -16'sd100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (last_acc) begin i_i = i_i + 1'b1; i_q = i_q - 1'b1; end
    end
    check_val("bp_hold", o_i, 100);
    check_val("bp_stall", o_ready_in, 0);
    i_ready_out = 1'b1;
    for (int g = 0; g < 40 && i_valid; g++) begin
      cycle();
      if (last_acc) begin
        if (i_i == 16'sd105) i_valid = 1'b0;
        else begin i_i = i_i + 1'b1; i_q = i_q - 1'b1; end
      end
    end
    repeat (3) cycle();
    check_val("bp_cnt", obs_i.size(), 6);
    for (int j = 0; j < obs_i.size(); j++) check_val("bp_order", obs_i[j], 100 + j);

    // Ratio 0 acts as 1; mid-run ratio change applies to the next run
    iratio = '0; clear_obs();
    send(3, 9, -9);
    repeat (2) cycle();
    check_val("r0_cnt", obs_i.size(), 3);
    iratio = RW'(4); clear_obs();
    send(2, 1, 1);
    iratio = RW'(2);
    send(4, 1, 1);
    repeat (2) cycle();
    check_val("rchg_cnt", obs_i.size(), 2);
    check_val("rchg_run4", obs_i[0], 4);
    check_val("rchg_run2", obs_i[1], 2);

    // Asynchronous reset mid-run with an output pending
    iratio = RW'(4); i_ready_out = 1'b0;
    send(7, 5, 5);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", o_valid, 0);
    check_val("arst_o_i", o_i, 0);
    check_val("arst_o_sat", o_sat, 0);
    check_val("arst_ready", o_ready_in, 1);
    rst_n = 1'b1;
    model_reset();
    i_ready_out = 1'b1; clear_obs();
    send(4, 7, -3);
    repeat (2) cycle();
    check_val("arst_cnt", obs_i.size(), 1);
    check_val("arst_sum_i", obs_i[0], 28);
    check_val("arst_sum_q", obs_q[0], -12);

    // Rounding
    iratio = RW'(2); ishift = SW'(2); clear_obs();
    i_valid = 1'b1; i_i = 16'sd1; i_q = '0; cycle();
    i_i = 16'sd2; cycle();
    i_valid = 1'b0;
    repeat (2) cycle();
    check_val("round_i", obs_i[0], ROUND ? 1 : 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 40) == 0) iratio = RW'($urandom_range(0, 70));
      ishift      = SW'($urandom_range(0, 9));
      i_valid     = ($urandom_range(0, 3) != 0);
      i_ready_out = ($urandom_range(0, 3) != 0);
      i_i = ($urandom_range(0, 3) == 0) ? 16'sh7fff : IQ_W'($urandom);
      i_q = ($urandom_range(0, 3) == 0) ? 16'sh8000 : IQ_W'($urandom);
      cycle();
    end
    i_valid = 1'b0; i_ready_out = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
